// File: rtl/sha_mem_responder.sv
// sha_mem_responder: word-addressed memory shared between a host loader and the
// hash engine's memory port. The host owns the array between jobs; the engine
// owns it from eng_start until one cycle after eng_done. The block also tracks
// which digest words the engine wrote back, and flags out-of-range accesses.
module sha_mem_responder #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 256,
  parameter logic [ADDR_W-1:0] DIGEST_BASE  = 'h80,
  parameter int                DIGEST_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              eng_start,
  input  logic              eng_done,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              digest_ready,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range limits are held one bit wider than the address so that neither the
  // depth nor the digest window end can wrap.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] DIG_LO  = {1'b0, DIGEST_BASE};
  localparam logic [ADDR_W:0] DIG_HI  = DIG_LO + (ADDR_W+1)'(DIGEST_WORDS);

  typedef enum logic [1:0] {
    ST_HOST   = 2'd0,
    ST_ENGINE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                   state;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DIGEST_WORDS-1:0]  mask;
  logic [DIGEST_WORDS-1:0]  mask_nxt;

  logic                     eng_own;
  logic                     eng_inrange;
  logic                     host_inrange;
  logic                     host_acc;
  logic                     host_rd;
  logic                     eng_wr;
  logic                     host_wr;
  logic                     eng_dig;
  logic [ADDR_W-1:0]        dig_off;
  logic [IDX_W-1:0]         eng_idx;
  logic [IDX_W-1:0]         host_idx;

  logic                     vld_p1;
  logic [DATA_W-1:0]        rdata_p1;
  logic [DATA_W-1:0]        mrd_p1;

  assign eng_own      = (state != ST_HOST);
  assign eng_inrange  = ({1'b0, mem_addr}  < DEPTH_L);
  assign host_inrange = ({1'b0, host_addr} < DEPTH_L);
  assign eng_idx      = mem_addr[IDX_W-1:0];
  assign host_idx     = host_addr[IDX_W-1:0];

  // Grant is combinational so the host may be served in the eng_start cycle;
  // it is masked during reset so that nothing is accepted while reset_n is low.
  assign host_acc = reset_n && host_req && (state == ST_HOST);
  assign host_gnt = host_acc;
  assign host_rd  = host_acc && !host_we;

  // Out-of-range writes are dropped on either port.
  assign eng_wr  = eng_own && mem_we && eng_inrange;
  assign host_wr = host_acc && host_we && host_inrange;

  // Digest window hit for an engine write; the offset selects the mask bit.
  assign eng_dig = eng_own && mem_we &&
                   ({1'b0, mem_addr} >= DIG_LO) && ({1'b0, mem_addr} < DIG_HI);
  assign dig_off = mem_addr - DIGEST_BASE;

  assign host_rvalid   = vld_p1;
  assign host_rdata    = rdata_p1;
  assign mem_read_data = mrd_p1;

  // Digest mask including this cycle's engine write, so a write in the DRAIN
  // cycle still counts toward the completion decision.
  always_comb begin
    mask_nxt = mask;
    if (eng_dig) begin
      for (int i = 0; i < DIGEST_WORDS; i++) begin
        if (dig_off == ADDR_W'(i)) mask_nxt[i] = 1'b1;
      end
    end
  end

  // Ownership FSM with digest tracking; busy and digest_ready are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_HOST;
      busy         <= 1'b0;
      mask         <= '0;
      digest_ready <= 1'b0;
    end else begin
      case (state)
        ST_HOST: begin
          if (eng_start) begin
            state        <= ST_ENGINE;
            busy         <= 1'b1;
            mask         <= '0;
            digest_ready <= 1'b0;
          end
        end
        ST_ENGINE: begin
          mask <= mask_nxt;
          if (eng_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          mask         <= mask_nxt;
          state        <= ST_HOST;
          busy         <= 1'b0;
          digest_ready <= &mask_nxt;
        end
        default: begin
          state <= ST_HOST;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port; the two writers never overlap because ownership is exclusive.
  always_ff @(posedge clk) begin
    if (eng_wr) begin
      mem[eng_idx] <= mem_write_data;
    end else if (host_wr) begin
      mem[host_idx] <= host_wdata;
    end
  end

  // Engine read stage: one-cycle latency while the engine owns the array;
  // the value is held while the host owns it. Reads see the pre-write word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mrd_p1 <= '0;
    end else if (eng_own) begin
      mrd_p1 <= eng_inrange ? mem[eng_idx] : '0;
    end
  end

  // Host read stage: data and valid for exactly one cycle after a granted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= host_rd;
      if (host_rd) rdata_p1 <= host_inrange ? mem[host_idx] : '0;
    end
  end

  // Sticky out-of-range flag covering granted host accesses and every engine
  // access (the engine reads each cycle it owns the array).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if ((host_acc && !host_inrange) || (eng_own && !eng_inrange)) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Testbench for sha_mem_responder: directed scenarios plus a randomized phase,
// all compared against a word-level reference model of the shared memory.
module tb_sha_mem_responder;

  localparam int DEPTH = 256;
  localparam logic [15:0] DBASE = 16'h80;
  localparam int DWORDS = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eng_start, eng_done, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_gnt, host_rvalid, busy, digest_ready, addr_err;

  always #5 clk = ~clk;

  sha_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .eng_start(eng_start), .eng_done(eng_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .busy(busy), .digest_ready(digest_ready),
    .addr_err(addr_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the memory, the memory words themselves, which
  // digest words the current job has produced, and the expected outputs.
  localparam int OWN_HOST = 0, OWN_JOB = 1, OWN_FINISH = 2;
  int          m_owner = OWN_HOST;
  logic [31:0] m_mem [DEPTH];
  bit          m_written [DWORDS];
  bit          m_ready = 0, m_err = 0, m_rvld = 0;
  logic [31:0] m_rdata = '0, m_mrd = '0;

  function automatic bit in_range(input logic [15:0] a);
    return int'(a) < DEPTH;
  endfunction

  task automatic model_reset();
    m_owner = OWN_HOST;
    foreach (m_written[i]) m_written[i] = 0;
    m_ready = 0; m_err = 0; m_rvld = 0; m_rdata = '0; m_mrd = '0;
  endtask

  task automatic check_outs(input string ctx);
    chk({ctx, ".busy"}, 32'(busy), 32'(m_owner != OWN_HOST));
    chk({ctx, ".rvalid"}, 32'(host_rvalid), 32'(m_rvld));
    if (m_rvld) chk({ctx, ".rdata"}, host_rdata, m_rdata);
    chk({ctx, ".mem_rd"}, mem_read_data, m_mrd);
    chk({ctx, ".dready"}, 32'(digest_ready), 32'(m_ready));
    chk({ctx, ".aerr"}, 32'(addr_err), 32'(m_err));
  endtask

  // One clock cycle: drive inputs, check the grant, advance the model, then
  // check registered outputs just after the edge.
  task automatic step(input bit req, input bit we, input logic [15:0] ha,
                      input logic [31:0] hd, input bit st, input bit dn,
                      input bit mwe, input logic [15:0] ma, input logic [31:0] md,
                      input string ctx);
    bit          gnt, own;
    logic [31:0] new_mrd;
    logic [15:0] off;
    host_req = req; host_we = we; host_addr = ha; host_wdata = hd;
    eng_start = st; eng_done = dn; mem_we = mwe; mem_addr = ma; mem_write_data = md;
    #1;
    gnt = req && (m_owner == OWN_HOST);
    own = (m_owner != OWN_HOST);
    chk({ctx, ".gnt"}, 32'(host_gnt), 32'(gnt));
    // reads observe the memory before this cycle's writes
    new_mrd = m_mrd;
    if (own) begin
      if (in_range(ma)) new_mrd = m_mem[ma[7:0]];
      else begin new_mrd = '0; m_err = 1; end
    end
    m_rvld = gnt && !we;
    if (m_rvld) m_rdata = in_range(ha) ? m_mem[ha[7:0]] : '0;
    if (gnt && !in_range(ha)) m_err = 1;
    m_mrd = new_mrd;
    if (own && mwe) begin
      if (in_range(ma)) m_mem[ma[7:0]] = md;
      if (ma >= DBASE && int'(ma) < int'(DBASE) + DWORDS) begin
        off = ma - DBASE;
        m_written[off[2:0]] = 1;
      end
    end
    if (gnt && we && in_range(ha)) m_mem[ha[7:0]] = hd;
    case (m_owner)
      OWN_HOST: if (st) begin
        m_owner = OWN_JOB;
        foreach (m_written[i]) m_written[i] = 0;
        m_ready = 0;
      end
      OWN_JOB: if (dn) m_owner = OWN_FINISH;
      default: begin
        m_owner = OWN_HOST;
        m_ready = 1;
        foreach (m_written[i]) if (!m_written[i]) m_ready = 0;
      end
    endcase
    @(posedge clk);
    #1;
    check_outs(ctx);
  endtask

  task automatic idle(input string ctx);
    step(0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, ctx);
  endtask

  logic [31:0] dig_words [DWORDS];
  logic [31:0] w;

  initial begin
    reset_n = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eng_start = 1'b0; eng_done = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst.gnt", 32'(host_gnt), 32'h0);
    check_outs("rst");
    reset_n = 1'b1;
    host_req = 1'b0;

    // Host load of the whole array; word 0 carries the known message word.
    for (int a = 0; a < DEPTH; a++) begin
      w = (a == 0) ? 32'h61626364 : $urandom;
      step(1, 1, 16'(a), w, 0, 0, 0, 16'h0, 32'h0, "load");
    end
    step(1, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, "hread0");
    chk("host_read0", host_rdata, 32'h61626364);
    idle("gap");
    chk("rvalid_one_cycle", 32'(host_rvalid), 32'h0);

    // Out-of-range host write is dropped (would alias onto word 0 if truncated).
    step(1, 1, 16'h0100, 32'hDEADBEEF, 0, 0, 0, 16'h0, 32'h0, "oor_wr");
    chk("addr_err_set", 32'(addr_err), 32'h1);
    step(1, 0, 16'h0100, 32'h0, 0, 0, 0, 16'h0, 32'h0, "oor_rd");
    chk("oor_read_zero", host_rdata, 32'h0);
    step(1, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, "alias_chk");
    chk("no_alias_write", host_rdata, 32'h61626364);

    // Host read granted in the eng_start cycle, then stalled while busy.
    step(1, 0, 16'h0, 32'h0, 1, 0, 0, 16'h0, 32'h0, "race");
    chk("race_rdata", host_rdata, 32'h61626364);
    step(1, 1, 16'h5, 32'h12345678, 0, 0, 0, 16'h0, 32'h0, "eng_rd");
    chk("eng_read0", mem_read_data, 32'h61626364);
    // Full digest write-back.
    for (int i = 0; i < DWORDS; i++) begin
      dig_words[i] = $urandom;
      step(1, 1, 16'h5, 32'h12345678, 0, 0, 1, DBASE + 16'(i), dig_words[i], "dig_wr");
    end
    step(0, 0, 16'h0, 32'h0, 0, 1, 0, 16'h0, 32'h0, "done");
    idle("drain");
    chk("digest_full", 32'(digest_ready), 32'h1);
    step(1, 0, DBASE + 16'h3, 32'h0, 0, 0, 0, 16'h0, 32'h0, "rd83");
    chk("digest_word3", host_rdata, dig_words[3]);

    // Partial digest: word 5 missing; the new start clears the prior flag.
    step(0, 0, 16'h0, 32'h0, 1, 0, 0, 16'h0, 32'h0, "p_start");
    chk("ready_cleared", 32'(digest_ready), 32'h0);
    for (int i = 0; i < DWORDS; i++) begin
      if (i != 5) step(0, 0, 16'h0, 32'h0, 0, 0, 1, DBASE + 16'(i), $urandom, "p_wr");
    end
    step(0, 0, 16'h0, 32'h0, 0, 1, 0, 16'h0, 32'h0, "p_done");
    idle("p_drain");
    chk("digest_partial", 32'(digest_ready), 32'h0);

    // Randomized traffic: random host accesses, engine jobs, stray pulses.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ha, ma;
      ha = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(256, 300)) : 16'($urandom_range(0, 255));
      ma = ($urandom_range(0, 2) == 0) ? DBASE + 16'($urandom_range(0, 7)) :
           (($urandom_range(0, 40) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255)));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ha, $urandom,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), ma, $urandom, "rand");
    end

    // Return to host ownership, then reset in the middle of a job.
    for (int n = 0; n < 4 && m_owner != OWN_HOST; n++)
      step(0, 0, 16'h0, 32'h0, 0, 1, 0, 16'h0, 32'h0, "settle");
    step(0, 0, 16'h0, 32'h0, 1, 0, 0, 16'h0, 32'h0, "mj_start");
    step(0, 0, 16'h0, 32'h0, 0, 0, 1, 16'h10, 32'hA5A5A5A5, "mj_wr");
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h20; host_wdata = 32'h0BADF00D;
    mem_we = 1'b1; mem_addr = 16'h11; mem_write_data = 32'hCAFEF00D;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mj.gnt", 32'(host_gnt), 32'h0);
    check_outs("mj_rst");
    @(posedge clk); #1;
    check_outs("mj_hold");
    reset_n = 1'b1;
    step(1, 0, 16'h11, 32'h0, 0, 0, 0, 16'h0, 32'h0, "mj_rd11");
    step(1, 0, 16'h10, 32'h0, 0, 0, 0, 16'h0, 32'h0, "mj_rd10");
    chk("mj_kept_write", host_rdata, 32'hA5A5A5A5);
    step(1, 0, 16'h20, 32'h0, 0, 0, 0, 16'h0, 32'h0, "mj_rd20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
